// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS phase generator.
// Widths match the 256-entry, 8-bit waveform ROMs.
package dds_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dds_state_t;

    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_BURST_WIDTH = 16;

    // Tuning word that advances the ROM address by one per clock
    localparam logic [DEF_ACC_WIDTH-1:0] FWORD_1STEP =
        DEF_ACC_WIDTH'(1) << (DEF_ACC_WIDTH - DEF_ADDR_WIDTH);

endpackage

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator producing ROM addresses with period-aligned
// config updates and optional N-period bursts.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ACC_WIDTH-1:0]   fword_in,
    input  logic [ADDR_WIDTH-1:0]  pword_in,
    input  logic                   cfg_load,
    input  logic [BURST_WIDTH-1:0] burst_cycles,
    input  logic                   start,
    input  logic                   stop,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   addr_valid,
    output logic                   rom_q_valid,
    output logic                   wrap,
    output logic                   done,
    output logic                   busy
);

    dds_state_t state_q, state_d;

    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   fword_act, fword_pend;
    logic [ADDR_WIDTH-1:0]  pword_act, pword_pend;
    logic [BURST_WIDTH-1:0] count, burst_n;

    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [ADDR_WIDTH-1:0]  acc_msb;
    logic                   carry;
    logic                   last;
    logic                   go;
    logic [ACC_WIDTH-1:0]   fword_pend_eff;
    logic [ADDR_WIDTH-1:0]  pword_pend_eff;
    logic [ADDR_WIDTH-1:0]  pword_idle;

    assign sum      = {1'b0, acc} + {1'b0, fword_act};
    assign carry    = sum[ACC_WIDTH];
    assign acc_next = sum[ACC_WIDTH-1:0];
    assign acc_msb  = acc_next[ACC_WIDTH-1 -: ADDR_WIDTH];
    assign go       = start && !stop;
    assign last     = carry && (burst_n != '0) &&
                      (BURST_WIDTH'(count + 1'b1) == burst_n);

    // A load on the carry edge itself still takes effect at that boundary
    assign fword_pend_eff = cfg_load ? fword_in : fword_pend;
    assign pword_pend_eff = cfg_load ? pword_in : pword_pend;
    assign pword_idle     = cfg_load ? pword_in : pword_act;

    assign busy       = (state_q == RUN);
    assign addr_valid = busy;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (go) state_d = RUN;
            RUN: begin
                if (stop)      state_d = IDLE;
                else if (go)   state_d = RUN;
                else if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc         <= '0;
            addr        <= '0;
            count       <= '0;
            burst_n     <= '0;
            fword_act   <= '0;
            fword_pend  <= '0;
            pword_act   <= '0;
            pword_pend  <= '0;
            wrap        <= 1'b0;
            done        <= 1'b0;
            rom_q_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrap        <= 1'b0;
            done        <= 1'b0;
            rom_q_valid <= busy;
            unique case (state_q)
                IDLE: begin
                    acc  <= '0;
                    addr <= pword_idle;
                    if (cfg_load) begin
                        fword_pend <= fword_in;
                        pword_pend <= pword_in;
                        fword_act  <= fword_in;
                        pword_act  <= pword_in;
                    end
                    if (go) begin
                        count   <= '0;
                        burst_n <= burst_cycles;
                    end
                end
                RUN: begin
                    if (cfg_load) begin
                        fword_pend <= fword_in;
                        pword_pend <= pword_in;
                    end
                    if (stop) begin
                        acc  <= '0;
                        addr <= pword_act;
                    end else if (go) begin
                        acc     <= '0;
                        count   <= '0;
                        burst_n <= burst_cycles;
                        addr    <= pword_act;
                    end else if (last) begin
                        acc  <= '0;
                        addr <= pword_act;
                        done <= 1'b1;
                    end else begin
                        acc <= acc_next;
                        if (carry) begin
                            wrap      <= 1'b1;
                            fword_act <= fword_pend_eff;
                            pword_act <= pword_pend_eff;
                            addr      <= acc_msb + pword_pend_eff;
                            if (count != '1) count <= count + 1'b1;
                        end else begin
                            addr <= acc_msb + pword_act;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed-vector bench for the DDS phase generator.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_dds_phase_gen;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fword_in;
    logic [7:0]  pword_in;
    logic        cfg_load;
    logic [15:0] burst_cycles;
    logic        start;
    logic        stop;
    logic [7:0]  addr;
    logic        addr_valid;
    logic        rom_q_valid;
    logic        wrap;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    dds_phase_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fword_in     (fword_in),
        .pword_in     (pword_in),
        .cfg_load     (cfg_load),
        .burst_cycles (burst_cycles),
        .start        (start),
        .stop         (stop),
        .addr         (addr),
        .addr_valid   (addr_valid),
        .rom_q_valid  (rom_q_valid),
        .wrap         (wrap),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cfg(input logic [31:0] f, input logic [7:0] p);
        fword_in = f;
        pword_in = p;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst_n    = 1'b0;
        start    = 1'b1;
        repeat (3) tick();
        obs = {3'b0, busy, addr_valid, rom_q_valid, wrap, done};
        checks++;
        if (obs !== 8'h00 || addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs flags=%h addr=%h want 00/00",
                     obs, addr);
        end
        rst_n    = 1'b1;
        start    = 1'b0;
        fword_in = 32'h0;
        pword_in = 8'h10;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        checks++;
        if (addr !== 8'h10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_pword addr=%h busy=%b want 10/0",
                     addr, busy);
        end
    endtask

    task automatic test_ramp();
        logic [7:0] ea;
        int bad;
        idle_cfg(FWORD_1STEP, 8'h00);
        burst_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (addr_valid !== 1'b1 || rom_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL ramp_first av=%b qv=%b want 1/0",
                     addr_valid, rom_q_valid);
        end
        bad = 0;
        for (int i = 0; i <= 256; i++) begin
            ea = 8'(i);
            if (i > 0) tick();
            checks++;
            if (addr !== ea || wrap !== (i == 256) || busy !== 1'b1) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL ramp_step i=%0d addr=%h wrap=%b want %h/%b",
                             i, addr, wrap, ea, (i == 256));
            end
            if (i == 1) begin
                checks++;
                if (rom_q_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL ramp_qvalid qv=%b want 1", rom_q_valid);
                end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 0 || done !== 0 || wrap !== 0 || rom_q_valid !== 1) begin
            failures++;
            $display("FAIL ramp_stop busy=%b done=%b wrap=%b qv=%b want 0/0/0/1",
                     busy, done, wrap, rom_q_valid);
        end
        tick();
        checks++;
        if (rom_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL ramp_qv_fall qv=%b want 0", rom_q_valid);
        end
    endtask

    task automatic test_burst();
        logic [7:0] ea;
        logic       ew;
        idle_cfg(32'h8000_0000, 8'h00);
        burst_cycles = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            ea = (i % 2) ? 8'h80 : 8'h00;
            ew = (i == 2 || i == 4);
            checks++;
            if (addr !== ea || wrap !== ew || busy !== 1 || done !== 0) begin
                failures++;
                $display("FAIL burst_c%0d addr=%h wrap=%b busy=%b done=%b want %h/%b/1/0",
                         i, addr, wrap, busy, done, ea, ew);
            end
        end
        tick();
        checks++;
        if (busy !== 0 || done !== 1 || wrap !== 0 || rom_q_valid !== 1) begin
            failures++;
            $display("FAIL burst_done busy=%b done=%b wrap=%b qv=%b want 0/1/0/1",
                     busy, done, wrap, rom_q_valid);
        end
        tick();
        checks++;
        if (done !== 0 || rom_q_valid !== 0) begin
            failures++;
            $display("FAIL burst_after done=%b qv=%b want 0/0",
                     done, rom_q_valid);
        end
    endtask

    task automatic test_deferred_cfg();
        logic [7:0] exp_a [4] = '{8'h20, 8'h60, 8'hA0, 8'hE0};
        idle_cfg(32'h8000_0000, 8'h00);
        burst_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (addr !== 8'h80) begin
            failures++;
            $display("FAIL defer_c1 addr=%h want 80", addr);
        end
        fword_in = 32'h4000_0000;
        pword_in = 8'h20;
        cfg_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cfg_load = 1'b0;
            checks++;
            if (addr !== exp_a[i] || wrap !== (i == 0)) begin
                failures++;
                $display("FAIL defer_c%0d addr=%h wrap=%b want %h/%b",
                         i + 2, addr, wrap, exp_a[i], (i == 0));
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_abort_restart();
        int dn;
        idle_cfg(32'h8000_0000, 8'h00);
        burst_cycles = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        dn = int'(done);
        for (int i = 0; i < 5; i++) begin
            tick();
            dn += int'(done);
        end
        checks++;
        if (busy !== 1'b0 || dn != 0) begin
            failures++;
            $display("FAIL abort busy=%b done_pulses=%0d want 0/0", busy, dn);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle busy=%b want 0", busy);
        end
        burst_cycles = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (addr !== 8'h00 || busy !== 1 || wrap !== 0 || done !== 0) begin
            failures++;
            $display("FAIL restart addr=%h busy=%b wrap=%b done=%b want 00/1/0/0",
                     addr, busy, wrap, done);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (busy !== (i < 4) || done !== (i == 4)) begin
                failures++;
                $display("FAIL restart_c%0d busy=%b done=%b want %b/%b",
                         i, busy, done, (i < 4), (i == 4));
            end
        end
    endtask

    task automatic test_zero_fword();
        int bad;
        idle_cfg(32'h0, 8'h33);
        burst_cycles = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) tick();
            if (addr !== 8'h33 || wrap !== 0 || done !== 0 || busy !== 1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL zero_fword bad_cycles=%0d want 0", bad);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_stop busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        idle_cfg(FWORD_1STEP, 8'h05);
        burst_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 0 || done !== 0 || addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b addr=%h want 0/0/00",
                     busy, done, addr);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (done !== 0 || rom_q_valid !== 0) begin
            failures++;
            $display("FAIL reset_mid_after done=%b qv=%b want 0/0",
                     done, rom_q_valid);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        fword_in     = '0;
        pword_in     = '0;
        cfg_load     = 1'b0;
        burst_cycles = '0;
        start        = 1'b0;
        stop         = 1'b0;
        test_reset();
        test_ramp();
        test_burst();
        test_deferred_cfg();
        test_abort_restart();
        test_zero_fword();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
